// File: rtl/melody_sequencer_pkg.sv
// Shared buzzer-path types: FSM states, timer modes, song entry layout,
// note codes and default timing.
package melody_sequencer_pkg;

   localparam int DEF_BEAT_TICKS = 12_500_000;
   localparam int DEF_GAP_TICKS  = 1_000_000;
   localparam int DEF_ADDR_W     = 6;
   localparam int DEF_DUR_W      = 4;
   localparam int NOTE_W         = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_DECODE,
      S_PLAY,
      S_GAP,
      S_REST,
      S_END
   } state_e;

   typedef enum logic [1:0] {
      TM_OFF,
      TM_PLAY,
      TM_GAP,
      TM_REST
   } tmode_e;

   typedef enum logic [NOTE_W-1:0] {
      NOTE_REST,
      NOTE_DO,
      NOTE_RE,
      NOTE_MI,
      NOTE_FA,
      NOTE_SO,
      NOTE_LA,
      NOTE_TI
   } note_e;

   // entry = {end_flag, rest, note, dur}, dur in the low bits
   function automatic int note_lsb(input int dur_w);
      return dur_w;
   endfunction

   function automatic int rest_bit(input int dur_w);
      return dur_w + NOTE_W;
   endfunction

   function automatic int end_bit(input int dur_w);
      return dur_w + NOTE_W + 1;
   endfunction

   function automatic int entry_w(input int dur_w);
      return dur_w + NOTE_W + 2;
   endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Song ROM read port and tone outputs toward the note clock divider.
interface melody_sequencer_if
   import melody_sequencer_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DUR_W  = DEF_DUR_W
);

   logic [ADDR_W-1:0]     song_addr;
   logic [DUR_W+4:0]      song_data;
   logic [NOTE_W-1:0]     note_number;
   logic                  note_en;

   modport master (
      output song_addr,
      output note_number,
      output note_en,
      input  song_data
   );

   modport slave (
      input  song_addr,
      input  note_number,
      input  note_en,
      output song_data
   );

endinterface

// File: rtl/melody_sequencer_beat_timer.sv
// Tick/beat counters for the timed states; expire marks the last
// counted cycle of a note, gap or rest.
module melody_sequencer_beat_timer
   import melody_sequencer_pkg::*;
#(
   parameter int BEAT_TICKS = DEF_BEAT_TICKS,
   parameter int GAP_TICKS  = DEF_GAP_TICKS,
   parameter int DUR_W      = DEF_DUR_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             pause,
   input  tmode_e           mode,
   input  logic [DUR_W-1:0] dur,
   output logic             expire
);

   localparam int TW = $clog2(BEAT_TICKS);
   localparam logic [TW-1:0] BEAT_LAST = TW'(BEAT_TICKS - 1);
   localparam logic [TW-1:0] PLAY_LAST =
      TW'(BEAT_TICKS - GAP_TICKS - 1);
   localparam logic [TW-1:0] GAP_LAST =
      TW'(GAP_TICKS > 0 ? GAP_TICKS - 1 : 0);

   logic [TW-1:0]    tick_q;
   logic [DUR_W-1:0] beat_q;
   logic             run;
   logic             last_beat;
   logic             hit;

   assign run       = (mode != TM_OFF) && !pause;
   assign last_beat = beat_q == dur - DUR_W'(1);

   // beat*BEAT_TICKS+tick reaches the target exactly on these pairs
   always_comb begin
      hit = 1'b0;
      unique case (mode)
         TM_PLAY: hit = last_beat && (tick_q == PLAY_LAST);
         TM_REST: hit = last_beat && (tick_q == BEAT_LAST);
         TM_GAP:  hit = tick_q == GAP_LAST;
         default: hit = 1'b0;
      endcase
   end

   assign expire = run && hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q <= '0;
         beat_q <= '0;
      end else if (load) begin
         tick_q <= '0;
         beat_q <= '0;
      end else if (run) begin
         if (tick_q == BEAT_LAST) begin
            tick_q <= '0;
            beat_q <= beat_q + 1'b1;
         end else begin
            tick_q <= tick_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/melody_sequencer.sv
// Song ROM walker driving the buzzer note divider.
// Optional SONG_LOOP_EN: restart from address 0 at song end when loop=1.
module melody_sequencer
   import melody_sequencer_pkg::*;
#(
   parameter int BEAT_TICKS = DEF_BEAT_TICKS,
   parameter int GAP_TICKS  = DEF_GAP_TICKS,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DUR_W      = DEF_DUR_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               pause,
   input  logic               loop,
   melody_sequencer_if.master bus,
   output logic               playing,
   output logic               done
);

   localparam int NLSB = note_lsb(DUR_W);
   localparam int RBIT = rest_bit(DUR_W);
   localparam int EBIT = end_bit(DUR_W);
   localparam int EW   = entry_w(DUR_W);

   state_e            state_q;
   state_e            state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;
   logic [NOTE_W-1:0] note_q;
   logic [NOTE_W-1:0] note_d;
   logic [EW-1:0]     entry_q;
   logic              note_en_q;
   logic              playing_q;
   logic              done_q;
   logic              pause_q;
   logic              adv;
   logic              expire;
   logic              load;
   logic              loop_en;
   tmode_e            tmode;

   logic              ent_end;
   logic              ent_rest;
   logic [NOTE_W-1:0] ent_note;
   logic [DUR_W-1:0]  ent_dur;
   logic              is_skip;
   logic              is_rest;

`ifdef SONG_LOOP_EN
   assign loop_en = loop;
`else
   logic unused_loop;
   assign unused_loop = loop;
   assign loop_en     = 1'b0;
`endif

   assign ent_end  = entry_q[EBIT];
   assign ent_rest = entry_q[RBIT];
   assign ent_note = entry_q[NLSB +: NOTE_W];
   assign ent_dur  = entry_q[DUR_W-1:0];

   assign is_skip = !ent_end && (ent_dur == '0);
   assign is_rest = !ent_end && (ent_dur != '0) &&
                    (ent_rest || ent_note == NOTE_REST);

   always_comb begin
      tmode = TM_OFF;
      unique case (state_q)
         S_PLAY:  tmode = TM_PLAY;
         S_GAP:   tmode = TM_GAP;
         S_REST:  tmode = TM_REST;
         default: tmode = TM_OFF;
      endcase
   end

   // every state change restarts the counters
   assign load = state_d != state_q;

   melody_sequencer_beat_timer #(
      .BEAT_TICKS(BEAT_TICKS),
      .GAP_TICKS (GAP_TICKS),
      .DUR_W     (DUR_W)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .pause (pause_q),
      .mode  (tmode),
      .dur   (ent_dur),
      .expire(expire)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      note_d  = note_q;
      adv     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH:  state_d = S_WAIT;
         S_WAIT:   state_d = S_DECODE;
         S_DECODE: begin
            unique case (1'b1)
               ent_end: state_d = S_END;
               is_skip: adv     = 1'b1;
               is_rest: state_d = S_REST;
               default: begin
                  state_d = S_PLAY;
                  note_d  = ent_note;
               end
            endcase
         end
         S_PLAY: begin
            if (expire) begin
               if (GAP_TICKS == 0) adv = 1'b1;
               else state_d = S_GAP;
            end
         end
         S_GAP, S_REST: begin
            if (expire) adv = 1'b1;
         end
         S_END: begin
            state_d = loop_en ? S_FETCH : S_IDLE;
            addr_d  = '0;
         end
         default: state_d = S_IDLE;
      endcase

      // the last ROM slot ends the song instead of wrapping
      if (adv) begin
         if (addr_q == '1) begin
            state_d = S_END;
         end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
         end
      end

      if (state_d == S_REST || state_d == S_END ||
          state_d == S_IDLE)
         note_d = '0;

      if (stop) begin
         state_d = S_IDLE;
         addr_d  = '0;
         note_d  = '0;
      end
   end

   // note_en and the timer both see pause one cycle late,
   // so sounded cycles always equal counted cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         note_q    <= '0;
         entry_q   <= '0;
         note_en_q <= 1'b0;
         playing_q <= 1'b0;
         done_q    <= 1'b0;
         pause_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         note_q    <= note_d;
         if (state_q == S_WAIT) entry_q <= bus.song_data;
         note_en_q <= (state_d == S_PLAY) && !pause;
         playing_q <= state_d != S_IDLE;
         done_q    <= state_d == S_END;
         pause_q   <= pause;
      end
   end

   assign bus.song_addr   = addr_q;
   assign bus.note_number = note_q;
   assign bus.note_en     = note_en_q;
   assign playing         = playing_q;
   assign done            = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: song table, spec-level trace model with
// random songs, and hand-written pause/stop/reset/wrap/loop sequences.
`timescale 1ns/1ps
module tb_melody_sequencer;
   import melody_sequencer_pkg::*;

   localparam int BT = 10;
   localparam int GT = 2;
   localparam int AW = 6;
   localparam int DW = 4;
   localparam logic [8:0] END_E = 9'h100;

   logic clk = 1'b0;
   logic rst_n, start, stop, pause, loop, playing, done;
   logic [8:0] rom [64];
   logic [5:0] exp_q [$];
   int n_chk = 0;
   int n_fail = 0;

   melody_sequencer_if #(.ADDR_W(AW), .DUR_W(DW)) bus ();

   melody_sequencer #(
      .BEAT_TICKS(BT), .GAP_TICKS(GT),
      .ADDR_W(AW), .DUR_W(DW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .stop(stop), .pause(pause), .loop(loop),
      .bus(bus), .playing(playing), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) bus.song_data <= rom[bus.song_addr];

   typedef struct {
      logic [8:0] e0, e1, e2;
      int len, high, addr;
      logic [2:0] note;
   } vec_t;
   vec_t vt [6];

   task automatic check(input string name,
                        input logic [31:0] got,
                        input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h",
                  name, got, want);
      end
   endtask

   function automatic logic [8:0] ent(input bit e, input bit r,
                                      input int n, input int d);
      logic [2:0] nn;
      logic [3:0] dd;
      nn = n[2:0];
      dd = d[3:0];
      return {e, r, nn, dd};
   endfunction

   function automatic logic [5:0] pk(input bit en, input bit pl,
                                     input bit dn,
                                     input logic [2:0] nt);
      return {en, pl, dn, en ? nt : 3'd0};
   endfunction

   task automatic fill(input logic [8:0] v);
      for (int i = 0; i < 64; i++) rom[i] = v;
   endtask

   // leaves us on the sample of the FETCH cycle
   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // expected per-cycle {note_en, playing, done, note} from the song rules
   task automatic build_trace();
      logic [8:0] e;
      int d;
      exp_q.delete();
      for (int a = 0; a < 65; a++) begin
         if (a == 64) begin
            exp_q.push_back(pk(0, 1, 1, 0));
            break;
         end
         e = rom[a];
         repeat (3) exp_q.push_back(pk(0, 1, 0, 0));
         if (e[8]) begin
            exp_q.push_back(pk(0, 1, 1, 0));
            break;
         end
         d = int'(e[3:0]);
         if (d == 0) continue;
         if (e[7] || e[6:4] == 3'd0) begin
            repeat (d * BT) exp_q.push_back(pk(0, 1, 0, 0));
         end else begin
            repeat (d * BT - GT) exp_q.push_back(pk(1, 1, 0, e[6:4]));
            repeat (GT) exp_q.push_back(pk(0, 1, 0, 0));
         end
      end
      repeat (2) exp_q.push_back(pk(0, 0, 0, 0));
   endtask

   task automatic run_trace(input string name);
      logic [5:0] g;
      build_trace();
      do_start();
      for (int i = 0; i < exp_q.size(); i++) begin
         g = {bus.note_en, playing, done,
              bus.note_en ? bus.note_number : 3'd0};
         check(name, 32'(g), 32'(exp_q[i]));
         @(negedge clk);
      end
   endtask

   task automatic run_song(input logic [2:0] note,
                           output int len, output int high,
                           output int dones, output int nbad,
                           output int done_addr);
      len = 0; high = 0; dones = 0; nbad = 0; done_addr = -1;
      do_start();
      for (int i = 0; i < 3000 && playing; i++) begin
         len++;
         if (bus.note_en) begin
            high++;
            if (bus.note_number !== note) nbad++;
         end
         if (done) begin
            dones++;
            done_addr = int'(bus.song_addr);
         end
         @(negedge clk);
      end
      check("done_after_idle", 32'(done), 0);
   endtask

   task automatic run_pause(input string name, input int on_at,
                            input int off_at, input int exp_len);
      int len, high, bad;
      len = 0; high = 0; bad = 0;
      if (on_at < 0) pause = 1'b1;
      do_start();
      for (int i = 0; i < 300 && playing; i++) begin
         len++;
         if (bus.note_en) begin
            high++;
            if (bus.note_number !== 3'd5) bad++;
            if (i > on_at && i <= off_at) bad++;
         end
         if (i == on_at) pause = 1'b1;
         if (i == off_at) pause = 1'b0;
         @(negedge clk);
      end
      check({name, "_high"}, 32'(high), 8);
      check({name, "_len"}, 32'(len), 32'(exp_len));
      check({name, "_bad"}, 32'(bad), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int len, high, dones, nbad, daddr;

      vt[0] = '{ent(0,0,NOTE_MI,2), END_E, END_E, 27, 18, 1, 3'd3};
      vt[1] = '{ent(0,1,NOTE_LA,1), ent(0,0,NOTE_SO,1), END_E,
                30, 8, 2, 3'd5};
      vt[2] = '{ent(0,0,NOTE_DO,1), ent(0,0,NOTE_RE,0), END_E,
                20, 8, 2, 3'd1};
      vt[3] = '{ent(0,0,NOTE_REST,2), END_E, END_E, 27, 0, 1, 3'd0};
      vt[4] = '{END_E, END_E, END_E, 4, 0, 0, 3'd0};
      vt[5] = '{ent(0,0,NOTE_TI,15), END_E, END_E, 157, 148, 1, 3'd7};

      rst_n = 1'b0; start = 1'b0; stop = 1'b0;
      pause = 1'b0; loop = 1'b0;
      fill(END_E);
      #12;
      check("reset_outputs",
            32'({playing, done, bus.note_en,
                 bus.note_number, bus.song_addr}), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int r = 0; r < 6; r++) begin
         fill(END_E);
         rom[0] = vt[r].e0; rom[1] = vt[r].e1; rom[2] = vt[r].e2;
         run_song(vt[r].note, len, high, dones, nbad, daddr);
         check($sformatf("tbl%0d_len", r), 32'(len), 32'(vt[r].len));
         check($sformatf("tbl%0d_high", r), 32'(high), 32'(vt[r].high));
         check($sformatf("tbl%0d_dones", r), 32'(dones), 1);
         check($sformatf("tbl%0d_note", r), 32'(nbad), 0);
         check($sformatf("tbl%0d_addr", r), 32'(daddr), 32'(vt[r].addr));
      end

      fill(END_E);
      rom[0] = ent(0, 0, NOTE_MI, 2);
      run_trace("trace_mi2");
      for (int t = 0; t < 10; t++) begin
         int n;
         n = $urandom_range(1, 6);
         fill(END_E);
         for (int k = 0; k < n; k++)
            rom[k] = ent(0, $urandom_range(0, 3) == 0,
                         $urandom_range(0, 7), $urandom_range(0, 3));
         run_trace($sformatf("rand_trace%0d", t));
      end

      fill(END_E);
      rom[0] = ent(0, 0, NOTE_SO, 1);
      run_pause("pause_mid", 5, 12, 24);
      run_pause("pause_at_start", -1, 10, 25);

      fill(0);
      run_song(3'd0, len, high, dones, nbad, daddr);
      check("wrap_len", 32'(len), 193);
      check("wrap_dones", 32'(dones), 1);
      check("wrap_end_addr", 32'(daddr), 63);
      check("wrap_idle_addr", 32'(bus.song_addr), 0);

      fill(END_E);
      rom[0] = ent(0, 0, NOTE_MI, 1);
      rom[1] = ent(0, 0, NOTE_FA, 1);
      rom[2] = ent(0, 0, NOTE_SO, 1);
      do_start();
      dones = 0;
      for (int i = 0; i < 24; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      check("gap_before_stop",
            32'({bus.note_en, bus.note_number, bus.song_addr}),
            32'({1'b0, 3'd4, 6'd1}));
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("stop_idle",
            32'({playing, bus.note_en, bus.song_addr}), 0);
      for (int i = 0; i < 40; i++) begin
         if (done || playing) dones++;
         @(negedge clk);
      end
      check("stop_no_done", 32'(dones), 0);
      do_start();
      check("replay_addr0", 32'(bus.song_addr), 0);
      repeat (3) @(negedge clk);
      check("replay_first_note",
            32'({bus.note_en, bus.note_number}), 32'({1'b1, 3'd3}));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("start_ignored_addr", 32'(bus.song_addr), 1);
      stop = 1'b1; start = 1'b1;
      @(negedge clk);
      stop = 1'b0; start = 1'b0;
      check("stop_beats_start", 32'(playing), 0);
      @(negedge clk);
      check("stop_start_stays_idle", 32'(playing), 0);

      fill(END_E);
      rom[0] = ent(0, 0, NOTE_MI, 1);
      loop = 1'b1;
      do_start();
      repeat (16) @(negedge clk);
      check("loop_done", 32'(done), 1);
      @(negedge clk);
`ifdef SONG_LOOP_EN
      check("loop_restart",
            32'({playing, bus.song_addr}), 32'({1'b1, 6'd0}));
      repeat (3) @(negedge clk);
      check("loop_replay_note",
            32'({bus.note_en, bus.note_number}), 32'({1'b1, 3'd3}));
      repeat (13) @(negedge clk);
      check("loop_done2", 32'(done), 1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("loop_stop", 32'(playing), 0);
`else
      check("loop_ignored",
            32'({playing, bus.song_addr}), 0);
`endif
      loop = 1'b0;

      fill(END_E);
      rom[0] = ent(0, 0, NOTE_MI, 2);
      do_start();
      repeat (5) @(negedge clk);
      check("pre_reset_play", 32'(bus.note_en), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset",
            32'({playing, done, bus.note_en,
                 bus.note_number, bus.song_addr}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("after_reset_idle", 32'(playing), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Upstream stage of the buzzer tone path. Walks a synchronous song ROM entry by entry.
- For each entry it drives a 3-bit note code plus an enable into the note clock divider for the programmed number of beats.
- Inserts a short articulation gap between notes; supports start, stop and pause.
- Signals song completion with a one-cycle done pulse.

Parameters:
- BEAT_TICKS, 12_500_000, clk cycles per beat unit (1/8 s at 100 MHz); must be ≥ 2.
- GAP_TICKS, 1_000_000, silent cycles at the end of each sounded note; must be < BEAT_TICKS.
- ADDR_W, 6, song ROM address width (64 entries).
- DUR_W, 4, duration field width in beats.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin playback from address 0.
- stop  in  1  synchronous abort; highest priority.
- pause  in  1  level; freezes playback while high.
- loop  in  1  level; restart the song at its end (only with SONG_LOOP_EN).
- song_addr  out  ADDR_W  ROM address; the ROM returns data exactly 1 cycle later.
- song_data  in  DUR_W+5  entry {end_flag, rest, note[2:0], dur[DUR_W-1:0]}.
- note_number  out  3  note code to the divider; held stable during a note.
- note_en  out  1  high while the tone sounds.
- playing  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on normal song completion.

Behaviour:
- Reset: state IDLE; song_addr=0; note_number=0; note_en=0; playing=0; done=0; all counters 0.
- All outputs are registered.
- States and transitions:
  - IDLE → FETCH on start.
  - FETCH drives song_addr, then goes to WAIT for 1 cycle.
  - WAIT → DECODE; DECODE registers song_data.
  - DECODE, end_flag=1 → END. Entry is not played.
  - DECODE, dur=0 → advance address → FETCH. Entry is skipped.
  - DECODE, rest=1 or note=0 → REST.
  - DECODE, otherwise → PLAY.
  - PLAY: note_en=1 for dur*BEAT_TICKS − GAP_TICKS cycles → GAP.
  - GAP: note_en=0 for GAP_TICKS cycles → advance address → FETCH.
  - REST: note_en=0 for dur*BEAT_TICKS cycles → advance address → FETCH.
  - END: done=1 for one cycle → IDLE, song_addr=0.
- Timing uses a tick counter (0..BEAT_TICKS−1) and a DUR_W-bit beat counter; compare against the full product, with no truncation.
- note_number is loaded in DECODE and holds through PLAY and GAP. It is 0 in REST, END and IDLE.
- Latency: start to the first note_en=1 is 4 cycles (FETCH, WAIT, DECODE, PLAY entry).
- Inter-note overhead: 3 cycles (FETCH, WAIT, DECODE) plus GAP_TICKS.
- Address wrap: advancing from 2^ADDR_W−1 is treated as the end of the song (go to END). The address never silently wraps into replay.
- Pause, high in PLAY, GAP or REST: all counters freeze and note_en is forced to 0.
- Pause release: note_en returns to its prior value and counting resumes. Total sounded time is unchanged.
- Pause in FETCH, WAIT or DECODE: takes effect once the next timed state is entered.
- Stop, any state: next cycle is IDLE; song_addr=0; note_en=0; no done pulse.
- Simultaneous start and stop: stop wins.
- start while playing=1 is ignored.
- pause=1 at start: playback enters PLAY with note_en held 0 until pause drops.
- Mid-operation asynchronous reset: immediate return to the reset values.

Optional Feature:
- Macro: SONG_LOOP_EN.
- Defined: in END with loop=1, the block still emits done and goes to FETCH with song_addr=0, and playing stays 1. With loop=0, behaviour is as below.
- Undefined: the loop input is ignored and END always returns to IDLE.

Decomposition:
- Shared buzzer package holds:
  - state encoding (IDLE, FETCH, WAIT, DECODE, PLAY, GAP, REST, END);
  - entry field bit positions and widths;
  - default BEAT_TICKS and GAP_TICKS;
  - note code constants 0=rest, 1..7=do..ti.
- One natural sub-module: beat_timer. It holds the tick and beat counters and takes load, dur, gap-mode and pause inputs, and outputs an expire strobe.

Test Plan:
- BEAT_TICKS=10, GAP_TICKS=2, ROM {note3 dur2; end} → note_en=1 for 18 cycles, then 0 for 2 cycles; note_number=3; done pulses once; playing falls after done.
- ROM {rest dur1; note5 dur1; end} → note_en=0 for 10 cycles, then high for 8 cycles with note_number=5.
- Pause for 7 cycles in the middle of a dur1 note → total high time is still 8; note_en=0 during the pause.
- Stop during GAP of entry 2 → IDLE next cycle; song_addr=0; done never asserted; a new start replays from entry 0.
- Entry with dur=0 between two notes → skipped with 3-cycle overhead; 64 entries with no end_flag → END after address 63.
- With SONG_LOOP_EN and loop=1 → after the end entry, done pulses and song_addr returns to 0; playback repeats.
- Without SONG_LOOP_EN → loop is ignored and the block returns to IDLE.
